// File: rtl/fpga_operand_entry_if.sv
// Operation bus from the operand-entry front end to the downstream consumer.
interface fpga_operand_entry_if;
    logic [31:0] port_a;
    logic [31:0] port_b;
    logic [3:0]  aluop;
    logic        op_valid;
    logic        op_ready;

    modport master (output port_a, output port_b, output aluop, output op_valid,
                    input  op_ready);
    modport slave  (input  port_a, input  port_b, input  aluop, input  op_valid,
                    output op_ready);
endinterface

// File: rtl/fpga_operand_entry.sv
// Board-input front end: synchronizes and debounces KEY, sequences A/B/opcode
// from SW into held registers and issues them over a valid/ready handshake.
module fpga_operand_entry #(
    parameter  int unsigned DEBOUNCE_CYCLES = 16,
    localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                    CLOCK_50,
    input  logic                    RST,
    input  logic [3:0]              KEY,
    input  logic [17:0]             SW,
    output logic [3:0]              key_press,
    output logic [1:0]              state,
    output logic [7:0]              issue_count,
    fpga_operand_entry_if.master    op
);

    localparam int unsigned NKEYS = 4;

    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        LOAD_OP = 2'b10,
        ISSUE   = 2'b11
    } state_t;

    logic [NKEYS-1:0] sync1, sync2, deb, deb_d;
    logic [CNT_W-1:0] cnt [NKEYS];

    state_t      state_q, state_n;
    logic [31:0] port_a_n, port_b_n;
    logic [3:0]  aluop_n;
    logic        op_valid_n;
    logic [7:0]  issue_count_n;
    logic [31:0] fmt;
    logic        unused_sw;

    assign fmt       = {{16{SW[16]}}, SW[15:0]};
    assign unused_sw = SW[17];
    assign state     = 2'(state_q);

    // Two-flop synchronizer, per-bit debounce and registered falling-edge pulse
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            sync1     <= '1;
            sync2     <= '1;
            deb       <= '1;
            deb_d     <= '1;
            key_press <= '0;
            for (int i = 0; i < int'(NKEYS); i++) cnt[i] <= '0;
        end else begin
            sync1     <= KEY;
            sync2     <= sync1;
            deb_d     <= deb;
            key_press <= deb_d & ~deb;
            for (int i = 0; i < int'(NKEYS); i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            state_q     <= LOAD_A;
            op.port_a   <= '0;
            op.port_b   <= '0;
            op.aluop    <= '0;
            op.op_valid <= 1'b0;
            issue_count <= '0;
        end else begin
            state_q     <= state_n;
            op.port_a   <= port_a_n;
            op.port_b   <= port_b_n;
            op.aluop    <= aluop_n;
            op.op_valid <= op_valid_n;
            issue_count <= issue_count_n;
        end
    end

    // Handshake completion first, then presses with KEY3 > KEY0 > KEY1
    always_comb begin
        state_n       = state_q;
        port_a_n      = op.port_a;
        port_b_n      = op.port_b;
        aluop_n       = op.aluop;
        op_valid_n    = op.op_valid;
        issue_count_n = issue_count;

        if (state_q == ISSUE && op.op_valid && op.op_ready) begin
            op_valid_n    = 1'b0;
            issue_count_n = issue_count + 8'd1;
            state_n       = LOAD_A;
        end

        if (key_press[3]) begin
            state_n    = LOAD_A;
            op_valid_n = 1'b0;
        end else if (key_press[0]) begin
            case (state_q)
                LOAD_A: begin
                    port_a_n = fmt;
                    state_n  = LOAD_B;
                end
                LOAD_B: begin
                    port_b_n = fmt;
                    state_n  = LOAD_OP;
                end
                LOAD_OP: begin
                    aluop_n    = SW[3:0];
                    op_valid_n = 1'b1;
                    state_n    = ISSUE;
                end
                default: ;
            endcase
        end else if (key_press[1]) begin
            case (state_q)
                LOAD_B:  state_n = LOAD_A;
                LOAD_OP: state_n = LOAD_B;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_operand_entry.sv
// Self-checking bench for fpga_operand_entry: directed vectors, corner sequences
// and randomized presses against a press-level reference model.
module tb_fpga_operand_entry;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  KEY;
    logic [17:0] SW;
    logic [3:0]  key_press;
    logic [1:0]  state;
    logic [7:0]  issue_count;

    int checks = 0;
    int errors = 0;

    fpga_operand_entry_if bus();

    fpga_operand_entry #(.DEBOUNCE_CYCLES(16)) dut (
        .CLOCK_50    (clk),
        .RST         (rst),
        .KEY         (KEY),
        .SW          (SW),
        .key_press   (key_press),
        .state       (state),
        .issue_count (issue_count),
        .op          (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          key;
        logic [17:0] sw;
        logic [1:0]  st;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        v;
        logic [7:0]  cnt;
    } vec_t;

    // Reference model, one step per complete press
    logic [1:0]  m_st;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_op;
    logic        m_v;
    logic [7:0]  m_cnt;

    function automatic logic [31:0] fmt(input logic [17:0] sw);
        return {{16{sw[16]}}, sw[15:0]};
    endfunction

    function automatic void model_reset();
        m_st = 2'd0; m_a = '0; m_b = '0; m_op = '0; m_v = 1'b0; m_cnt = '0;
    endfunction

    function automatic void model_handshake(input logic rdy);
        if (m_st == 2'd3 && rdy) begin
            m_cnt = m_cnt + 8'd1;
            m_v   = 1'b0;
            m_st  = 2'd0;
        end
    endfunction

    function automatic void model_press(input int k, input logic [17:0] sw, input logic rdy);
        model_handshake(rdy);
        if (k == 3) begin
            m_st = 2'd0;
            m_v  = 1'b0;
        end else if (k == 0) begin
            if (m_st == 2'd0)      begin m_a = fmt(sw); m_st = 2'd1; end
            else if (m_st == 2'd1) begin m_b = fmt(sw); m_st = 2'd2; end
            else if (m_st == 2'd2) begin m_op = sw[3:0]; m_v = 1'b1; m_st = 2'd3; end
        end else if (k == 1) begin
            if (m_st == 2'd1)      m_st = 2'd0;
            else if (m_st == 2'd2) m_st = 2'd1;
        end
        model_handshake(rdy);
    endfunction

    function automatic logic [78:0] dut_vec();
        return {state, bus.port_a, bus.port_b, bus.aluop, bus.op_valid, issue_count};
    endfunction

    function automatic logic [78:0] model_vec();
        return {m_st, m_a, m_b, m_op, m_v, m_cnt};
    endfunction

    task automatic chk(input string nm, input logic [78:0] act, input logic [78:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        model_reset();
        chk("reset", {4'(key_press), dut_vec()}, {4'h0, 79'h0});
    endtask

    // Full press: hold low long enough to debounce, then release and settle
    task automatic press(input int k, input logic [17:0] sw, input logic rdy);
        int pc [4];
        for (int j = 0; j < 4; j++) pc[j] = 0;
        SW = sw;
        bus.op_ready = rdy;
        if (k < 4) KEY[k] = 1'b0;
        for (int c = 0; c < 44; c++) begin
            if (c == 22) KEY = 4'hF;
            @(posedge clk);
            #1;
            for (int j = 0; j < 4; j++) if (key_press[j]) pc[j]++;
        end
        bus.op_ready = 1'b0;
        model_press(k, sw, rdy);
        for (int j = 0; j < 4; j++)
            chk($sformatf("pulse_count_k%0d_bit%0d", k, j), 79'(pc[j]), 79'((j == k) ? 1 : 0));
    endtask

    vec_t vt [13];

    initial begin
        int first_hi, hi_cnt, changes, seen;
        logic [78:0] held;

        rst = 1'b1; KEY = 4'hF; SW = '0; bus.op_ready = 1'b0;
        vt[0]  = '{1, 18'h00000, 2'd0, 32'h00001234, 32'h0,  4'h0, 1'b0, 8'd0};
        vt[1]  = '{0, 18'h18000, 2'd1, 32'hFFFF8000, 32'h0,  4'h0, 1'b0, 8'd0};
        vt[2]  = '{0, 18'h00005, 2'd2, 32'hFFFF8000, 32'h5,  4'h0, 1'b0, 8'd0};
        vt[3]  = '{1, 18'h00000, 2'd1, 32'hFFFF8000, 32'h5,  4'h0, 1'b0, 8'd0};
        vt[4]  = '{0, 18'h00007, 2'd2, 32'hFFFF8000, 32'h7,  4'h0, 1'b0, 8'd0};
        vt[5]  = '{0, 18'h00003, 2'd3, 32'hFFFF8000, 32'h7,  4'h3, 1'b1, 8'd0};
        vt[6]  = '{0, 18'h00009, 2'd3, 32'hFFFF8000, 32'h7,  4'h3, 1'b1, 8'd0};
        vt[7]  = '{1, 18'h00000, 2'd3, 32'hFFFF8000, 32'h7,  4'h3, 1'b1, 8'd0};
        vt[8]  = '{2, 18'h00000, 2'd3, 32'hFFFF8000, 32'h7,  4'h3, 1'b1, 8'd0};
        vt[9]  = '{3, 18'h00000, 2'd0, 32'hFFFF8000, 32'h7,  4'h3, 1'b0, 8'd0};
        vt[10] = '{0, 18'h30001, 2'd1, 32'hFFFF0001, 32'h7,  4'h3, 1'b0, 8'd0};
        vt[11] = '{0, 18'h000A0, 2'd2, 32'hFFFF0001, 32'hA0, 4'h3, 1'b0, 8'd0};
        vt[12] = '{0, 18'h0000C, 2'd3, 32'hFFFF0001, 32'hA0, 4'hC, 1'b1, 8'd0};

        @(posedge clk); #1;
        do_reset();

        // Press latency: KEY0 low after edge 0, pulse only after edge 19
        SW = 18'h21234;
        KEY[0] = 1'b0;
        first_hi = -1; hi_cnt = 0;
        for (int n = 1; n <= 25; n++) begin
            @(posedge clk); #1;
            if (key_press[0]) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = n;
            end
        end
        KEY = 4'hF;
        cycles(22);
        chk("press_latency_edge", 79'(first_hi), 79'(19));
        chk("press_width", 79'(hi_cnt), 79'(1));
        chk("after_first_press", dut_vec(), {2'd1, 32'h00001234, 32'h0, 4'h0, 1'b0, 8'd0});

        // Glitches shorter than the debounce window are rejected
        hi_cnt = 0;
        for (int r = 0; r < 3; r++) begin
            KEY[1] = 1'b0;
            for (int c = 0; c < 10; c++) begin @(posedge clk); #1; if (key_press[1]) hi_cnt++; end
            KEY = 4'hF;
            for (int c = 0; c < 10; c++) begin @(posedge clk); #1; if (key_press[1]) hi_cnt++; end
        end
        cycles(10);
        chk("glitch_pulses", 79'(hi_cnt), 79'(0));
        chk("glitch_state", dut_vec(), {2'd1, 32'h00001234, 32'h0, 4'h0, 1'b0, 8'd0});

        for (int i = 0; i < 13; i++) begin
            press(vt[i].key, vt[i].sw, 1'b0);
            chk($sformatf("vec%0d", i), dut_vec(),
                {vt[i].st, vt[i].a, vt[i].b, vt[i].op, vt[i].v, vt[i].cnt});
        end

        // Stall: outputs hold while op_ready is low
        held = dut_vec();
        changes = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (dut_vec() !== held) changes++;
        end
        chk("stall_stable", 79'(changes), 79'(0));
        bus.op_ready = 1'b1;
        @(posedge clk); #1;
        bus.op_ready = 1'b0;
        chk("handshake", dut_vec(), {2'd0, 32'hFFFF0001, 32'hA0, 4'hC, 1'b0, 8'd1});

        // Abort coinciding with a completing handshake still counts it
        press(0, 18'h00002, 1'b0);
        press(0, 18'h00004, 1'b0);
        press(0, 18'h00005, 1'b0);
        chk("pre_abort_issue", dut_vec(), {2'd3, 32'h2, 32'h4, 4'h5, 1'b1, 8'd1});
        KEY[3] = 1'b0;
        seen = 0;
        for (int c = 0; c < 40 && seen == 0; c++) begin
            @(posedge clk); #1;
            if (key_press[3]) seen = 1;
        end
        chk("abort_pulse_seen", 79'(seen), 79'(1));
        bus.op_ready = 1'b1;
        @(posedge clk); #1;
        bus.op_ready = 1'b0;
        chk("abort_with_handshake", dut_vec(), {2'd0, 32'h2, 32'h4, 4'h5, 1'b0, 8'd2});
        KEY = 4'hF;
        cycles(22);

        // Randomized presses against the model
        do_reset();
        for (int i = 0; i < 250; i++) begin
            int k;
            logic [17:0] sw;
            logic rdy;
            case ($urandom_range(0, 5))
                0, 1, 2: k = 0;
                3:       k = 1;
                4:       k = 2;
                default: k = 3;
            endcase
            sw  = 18'($urandom);
            rdy = ($urandom_range(0, 3) == 0);
            press(k, sw, rdy);
            chk($sformatf("rand%0d", i), dut_vec(), model_vec());
        end

        // Count wrap after 256 handshakes
        do_reset();
        for (int i = 1; i <= 256; i++) begin
            press(0, 18'($urandom), 1'b0);
            press(0, 18'($urandom), 1'b0);
            press(0, 18'($urandom), 1'b0);
            bus.op_ready = 1'b1;
            @(posedge clk); #1;
            bus.op_ready = 1'b0;
            model_handshake(1'b1);
            if (i >= 254) chk($sformatf("wrap%0d", i), dut_vec(), model_vec());
        end
        chk("wrap_zero", 79'(issue_count), 79'(0));

        // Reset while issuing clears everything on that edge
        press(0, 18'h1FFFF, 1'b0);
        press(0, 18'h1FFFF, 1'b0);
        press(0, 18'h0000F, 1'b0);
        chk("pre_reset_issue", dut_vec(), model_vec());
        rst = 1'b1;
        @(posedge clk); #1;
        chk("reset_in_issue", {4'(key_press), dut_vec()}, {4'h0, 79'h0});
        rst = 1'b0;
        cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
